// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: shared state encoding, PIO field positions and parity helper for ps2_cmd_tx
package ps2_tx_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, STOP, ACK, DONE} state_e;
    localparam int TOGGLE_BIT = 31;
    localparam int CMD_LSB = 0;
    localparam int CMD_MSB = 7;
    localparam logic [3:0] LAST_DATA_IDX = 4'd8;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_cmd_tx_sync.sv
// ps2_sync_edge: multi-stage synchronizer for a PS/2 line plus a registered falling-edge pulse
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fall_q;
    // Flops reset to the idle-high bus level so release from reset never looks like an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end
    assign sync_o = sync_q[SYNC_STAGES-1];
    assign fall_o = fall_q;
endmodule

// File: rtl/ps2_cmd_tx.sv
// ps2_cmd_tx: turns a toggle-qualified PIO command byte into a PS/2 host-to-device transfer.
// Define PS2_TX_TIMEOUT_EN to build the REQ-to-ACK watchdog; without it only reset recovers a silent device.
module ps2_cmd_tx
    import ps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pio_word,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe,
    output logic        busy,
    output logic        done_toggle,
    output logic        ack_err
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    state_e           state_q, state_d;
    logic             tgl_q, tgl_d;
    logic [7:0]       byte_q, byte_d, shift_q, shift_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [INH_W-1:0] tmr_q, tmr_d;
    logic             clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
    logic             fall_p, dat_sync, accept, timeout;
    logic             unused_clk_sync, unused_dat_fall, unused_pio_bits;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk(clk), .reset_n(reset_n), .async_i(ps2_clk_i), .sync_o(unused_clk_sync), .fall_o(fall_p)
    );
    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
        .clk(clk), .reset_n(reset_n), .async_i(ps2_dat_i), .sync_o(dat_sync), .fall_o(unused_dat_fall)
    );

    assign unused_pio_bits = ^pio_word[30:8];
    assign accept = (state_q == IDLE) && (pio_word[TOGGLE_BIT] != tgl_q);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            in_wd;
    assign in_wd   = state_q inside {REQ, DATA, STOP, ACK};
    assign timeout = in_wd && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    // Watchdog runs from REQ entry and is cleared whenever the bus phases are not active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wd_q <= '0;
        else          wd_q <= in_wd ? wd_q + 1'b1 : '0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register and all registered outputs; reset drops both bus drivers at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tgl_q     <= 1'b0;
            byte_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgl_q     <= tgl_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Next-state logic; a watchdog expiry overrides any same-cycle device clock edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = INHIBIT;
            INHIBIT: if (tmr_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = REQ;
            REQ:     state_d = DATA;
            DATA:    if (fall_p && cnt_q == LAST_DATA_IDX) state_d = STOP;
            STOP:    if (fall_p) state_d = ACK;
            ACK:     if (fall_p) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = DONE;
    end

    // Outputs and datapath; line drivers lag the state by one cycle so INHIBIT holds clock low exactly INHIBIT_CYCLES
    always_comb begin
        tgl_d     = tgl_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tmr_d     = (state_q == INHIBIT) ? tmr_q + 1'b1 : '0;
        clk_oe_d  = (state_q == INHIBIT);
        dat_oe_d  = dat_oe_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ack_err_d = ack_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgl_d   = pio_word[TOGGLE_BIT];
                    byte_d  = pio_word[CMD_MSB:CMD_LSB];
                    shift_d = pio_word[CMD_MSB:CMD_LSB];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            REQ: dat_oe_d = 1'b1;
            DATA: begin
                if (fall_p) begin
                    dat_oe_d = ~((cnt_q == LAST_DATA_IDX) ? odd_parity(byte_q) : shift_q[0]);
                    shift_d  = shift_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            STOP: if (fall_p) dat_oe_d = 1'b0;
            ACK:  if (fall_p) ack_err_d = dat_sync;
            DONE: begin
                done_d = ~done_q;
                busy_d = 1'b0;
            end
            default: ;
        endcase
        if (timeout) begin
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            ack_err_d = 1'b1;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign busy        = busy_q;
    assign done_toggle = done_q;
    assign ack_err     = ack_err_q;
endmodule

// File: tb/tb_ps2_cmd_tx.sv
// tb_ps2_cmd_tx: randomized bench for ps2_cmd_tx with an open-drain bus and a PS/2 device model
module tb_ps2_cmd_tx;
    localparam int INH = 60;
    localparam int TO  = 2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pio_word = '0;
    logic        dev_clk_low = 1'b0;
    logic        dev_dat_low = 1'b0;
    logic        clk_line, dat_line;
    logic        ps2_clk_oe, ps2_dat_oe, busy, done_toggle, ack_err;
    int          checks = 0;
    int          errors = 0;
    logic        tgl = 1'b0;
    logic        exp_done = 1'b0;
    int          run = 0;
    int          last_run = 0;

    assign clk_line = !(ps2_clk_oe || dev_clk_low);
    assign dat_line = !(ps2_dat_oe || dev_dat_low);

    always #5 clk = ~clk;

    ps2_cmd_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .pio_word(pio_word),
        .ps2_clk_i(clk_line), .ps2_dat_i(dat_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .busy(busy), .done_toggle(done_toggle), .ack_err(ack_err)
    );

    // Length of the most recent run of host clock inhibit, in cycles
    always @(negedge clk) begin
        if (ps2_clk_oe) run <= run + 1;
        else if (run != 0) begin
            last_run <= run;
            run <= 0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] b);
        tgl = ~tgl;
        pio_word = {tgl, 23'($urandom), b};
    endtask

    task automatic wait_inhibit();
        int n = 0;
        while (!ps2_clk_oe && n < 1000) begin @(negedge clk); n++; end
        check("inhibit_seen", {31'd0, ps2_clk_oe}, 1);
        n = 0;
        while (ps2_clk_oe && n < 4 * INH) begin @(negedge clk); n++; end
        #1;
        check("inhibit_len", last_run, INH);
        check("start_bit", {31'd0, dat_line}, 0);
        check("busy_mid", {31'd0, busy}, 1);
    endtask

    task automatic pulses(input int nbits, input int half, output logic [10:0] got);
        got = '0;
        for (int k = 0; k < nbits; k++) begin
            cycles(half);
            dev_clk_low = 1'b1;
            cycles(half);
            got[k] = dat_line;
            dev_clk_low = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_toggle === exp_done && n < 200) begin @(negedge clk); n++; end
        exp_done = ~exp_done;
        check("done_toggle", {31'd0, done_toggle}, {31'd0, exp_done});
        check("busy_end", {31'd0, busy}, 0);
        check("lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    // Device side of one command: receive 8 data bits, parity and stop, then ack (data low) or nack
    task automatic dev_xfer(input logic [7:0] cmd, input logic ack, input int half);
        logic [10:0] got;
        wait_inhibit();
        pulses(10, half, got);
        check("data_bits", {24'd0, got[7:0]}, {24'd0, cmd});
        check("parity", {31'd0, got[8]}, ($countones(cmd) % 2 == 0) ? 1 : 0);
        check("stop_bit", {31'd0, got[9]}, 1);
        cycles(half);
        dev_dat_low = ack;
        cycles(2);
        dev_clk_low = 1'b1;
        wait_done();
        check("ack_err", {31'd0, ack_err}, {31'd0, !ack});
        cycles(half);
        dev_clk_low = 1'b0;
        cycles(2);
        dev_dat_low = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic        ack;
        logic [10:0] got;
        int          half;
        int          hi;
        cycles(5);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done_toggle}, 0);
        check("rst_ack_err", {31'd0, ack_err}, 0);
        reset_n = 1'b1;
        cycles(10);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_clk_oe", {31'd0, ps2_clk_oe}, 0);

        issue(8'hF4);
        dev_xfer(8'hF4, 1'b1, $urandom_range(15, 30));
        issue(8'hFF);
        dev_xfer(8'hFF, 1'b0, $urandom_range(15, 30));

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            issue(b);
            dev_xfer(b, ack, $urandom_range(12, 30));
        end

        b = 8'($urandom);
        half = $urandom_range(12, 25);
        issue(b);
        cycles(5);
        issue(8'hE8);
        dev_xfer(b, 1'b1, half);
        dev_xfer(8'hE8, 1'b1, half);

        b = 8'($urandom);
        issue(b);
        cycles(5);
        issue(8'($urandom));
        cycles(5);
        issue(8'($urandom));
        dev_xfer(b, 1'b1, half);
        hi = 0;
        for (int i = 0; i < 3 * INH; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) hi++;
        end
        check("no_second_xfer", hi, 0);
        check("no_second_busy", {31'd0, busy}, 0);

`ifdef PS2_TX_TIMEOUT_EN
        issue(8'($urandom));
        wait_inhibit();
        hi = 0;
        while (ps2_dat_oe && hi < 3 * TO) begin @(negedge clk); hi++; end
        // Clock release is seen one cycle after REQ entry; the drivers drop TO cycles after REQ entry
        check("timeout_len", hi, TO - 1);
        wait_done();
        check("timeout_ack_err", {31'd0, ack_err}, 1);
`endif

        b = 8'($urandom);
        half = $urandom_range(12, 25);
        issue(b);
        wait_inhibit();
        pulses(3, half, got);
        cycles(half);
        dev_clk_low = 1'b1;
        cycles(6);
        check("bit3_driven", {31'd0, dat_line}, {31'd0, b[3]});
        reset_n = 1'b0;
        pio_word = '0;
        tgl = 1'b0;
        #1;
        check("midrst_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("midrst_dat_oe", {31'd0, ps2_dat_oe}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        dev_clk_low = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        exp_done = 1'b0;
        cycles(20);
        check("post_rst_busy", {31'd0, busy}, 0);
        check("post_rst_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("post_rst_done", {31'd0, done_toggle}, {31'd0, exp_done});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
